// File: rtl/usb_token_rx.sv
// USB token packet decoder: validates PID, CRC5 and packet framing of PID/byte1/byte2
// and presents decoded OUT/IN/SOF/SETUP tokens with registered status pulses.
module usb_token_rx #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter bit CHECK_ADDR     = 1'b0
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] rx_data,
  input  logic       rx_data_ready,
  input  logic       eop,
  input  logic       rx_error,
  input  logic [6:0] dev_addr,
  output logic       tok_valid,
  output logic [3:0] tok_pid,
  output logic [6:0] tok_addr,
  output logic [3:0] tok_endp,
  output logic       pid_err,
  output logic       crc_err,
  output logic       pkt_err,
  output logic       busy
);

  localparam int         TIMER_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [4:0] CRC_SEED = 5'b11111;
  localparam logic [4:0] CRC_GOOD = 5'b01100;
  localparam logic [4:0] CRC_POLY = 5'b00101;
  localparam logic [3:0] PID_SOF  = 4'b0101;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    CRCB    = 3'd2,
    EOPW    = 3'd3,
    DISCARD = 3'd4
  } state_t;

  // Eight LSB-first CRC5 steps folded into one byte update.
  function automatic logic [4:0] crc5_byte(input logic [4:0] crc_in, input logic [7:0] data);
    logic [4:0] c;
    logic       fb;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      fb = data[i] ^ c[4];
      c  = {c[3:0], 1'b0} ^ (fb ? CRC_POLY : 5'b00000);
    end
    return c;
  endfunction

  function automatic logic pid_ok(input logic [7:0] pid);
    return pid[7:4] == ~pid[3:0];
  endfunction

  state_t             state_r, state_s;
  logic [TIMER_W-1:0] timer_r, timer_s;
  logic [4:0]         crc_r, crc_s;
  logic [3:0]         pid_r, pid_s;
  logic [6:0]         addr_r, addr_s;
  logic [3:0]         endp_r, endp_s;
  logic               tok_s, pid_err_s, crc_err_s, pkt_err_s;
  logic               timeout_s, filtered_s;

  assign timeout_s  = (timer_r == TIMER_W'(TIMEOUT_CYCLES - 1));
  assign filtered_s = CHECK_ADDR && (pid_r != PID_SOF) && (addr_r != dev_addr);

  // Next-state, field capture and status-pulse decode.
  always_comb begin
    state_s   = state_r;
    crc_s     = crc_r;
    pid_s     = pid_r;
    addr_s    = addr_r;
    endp_s    = endp_r;
    tok_s     = 1'b0;
    pid_err_s = 1'b0;
    crc_err_s = 1'b0;
    pkt_err_s = 1'b0;
    if (rx_error) begin
      state_s = IDLE;
    end else if (state_r == IDLE) begin
      // A PID byte coinciding with eop is still taken as a PID; eop alone is ignored.
      if (rx_data_ready) begin
        if (!pid_ok(rx_data)) begin
          pid_err_s = 1'b1;
          state_s   = DISCARD;
        end else if (rx_data[1:0] != 2'b01) begin
          state_s = DISCARD;
        end else begin
          pid_s   = rx_data[3:0];
          crc_s   = CRC_SEED;
          state_s = ADDR;
        end
      end else begin
        state_s = IDLE;
      end
    end else if (rx_data_ready && eop) begin
      pkt_err_s = (state_r != DISCARD);
      state_s   = IDLE;
    end else if (!rx_data_ready && !eop && timeout_s) begin
      pkt_err_s = (state_r != DISCARD);
      state_s   = IDLE;
    end else begin
      case (state_r)
        ADDR: begin
          if (rx_data_ready) begin
            addr_s  = rx_data[6:0];
            endp_s  = {3'b000, rx_data[7]};
            crc_s   = crc5_byte(crc_r, rx_data);
            state_s = CRCB;
          end else if (eop) begin
            pkt_err_s = 1'b1;
            state_s   = IDLE;
          end else begin
            state_s = ADDR;
          end
        end
        CRCB: begin
          if (rx_data_ready) begin
            endp_s  = {rx_data[2:0], endp_r[0]};
            crc_s   = crc5_byte(crc_r, rx_data);
            state_s = EOPW;
          end else if (eop) begin
            pkt_err_s = 1'b1;
            state_s   = IDLE;
          end else begin
            state_s = CRCB;
          end
        end
        EOPW: begin
          if (eop) begin
            state_s = IDLE;
            if (crc_r == CRC_GOOD) begin
              tok_s = !filtered_s;
            end else begin
              crc_err_s = 1'b1;
            end
          end else if (rx_data_ready) begin
            pkt_err_s = 1'b1;
            state_s   = DISCARD;
          end else begin
            state_s = EOPW;
          end
        end
        DISCARD: begin
          if (eop) begin
            state_s = IDLE;
          end else begin
            state_s = DISCARD;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // Inter-byte timer restarts on every byte and whenever the decoder is idle.
  always_comb begin
    if ((state_s == IDLE) || rx_data_ready) begin
      timer_s = '0;
    end else begin
      timer_s = timer_r + TIMER_W'(1);
    end
  end

  // Packet state and working fields.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= IDLE;
      timer_r <= '0;
      crc_r   <= CRC_SEED;
      pid_r   <= 4'h0;
      addr_r  <= 7'h00;
      endp_r  <= 4'h0;
    end else begin
      state_r <= state_s;
      timer_r <= timer_s;
      crc_r   <= crc_s;
      pid_r   <= pid_s;
      addr_r  <= addr_s;
      endp_r  <= endp_s;
    end
  end

  // Registered outputs; token fields move only on a good, unfiltered token.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tok_valid <= 1'b0;
      tok_pid   <= 4'h0;
      tok_addr  <= 7'h00;
      tok_endp  <= 4'h0;
      pid_err   <= 1'b0;
      crc_err   <= 1'b0;
      pkt_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      tok_valid <= tok_s;
      pid_err   <= pid_err_s;
      crc_err   <= crc_err_s;
      pkt_err   <= pkt_err_s;
      busy      <= (state_s != IDLE);
      if (tok_s) begin
        tok_pid  <= pid_r;
        tok_addr <= addr_r;
        tok_endp <= endp_r;
      end else begin
        tok_pid  <= tok_pid;
        tok_addr <= tok_addr;
        tok_endp <= tok_endp;
      end
    end
  end

endmodule

// File: tb/tb_usb_token_rx.sv
// Scoreboard bench for usb_token_rx: one instance without and one with address filtering
// (dev_addr=5) share the stimulus; a negedge monitor pops expected events per instance.
module tb_usb_token_rx;

  localparam int TMO = 64;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_data_ready = 1'b0;
  logic       eop = 1'b0;
  logic       rx_error = 1'b0;
  logic [6:0] dev_addr = 7'd5;

  logic       tv_a, pe_a, ce_a, ke_a, busy_a;
  logic [3:0] pid_a, endp_a;
  logic [6:0] addr_a;
  logic       tv_f, pe_f, ce_f, ke_f, busy_f;
  logic [3:0] pid_f, endp_f;
  logic [6:0] addr_f;

  usb_token_rx #(.TIMEOUT_CYCLES(TMO), .CHECK_ADDR(1'b0)) dut_a (
    .clk(clk), .n_rst(n_rst), .rx_data(rx_data), .rx_data_ready(rx_data_ready),
    .eop(eop), .rx_error(rx_error), .dev_addr(dev_addr),
    .tok_valid(tv_a), .tok_pid(pid_a), .tok_addr(addr_a), .tok_endp(endp_a),
    .pid_err(pe_a), .crc_err(ce_a), .pkt_err(ke_a), .busy(busy_a));

  usb_token_rx #(.TIMEOUT_CYCLES(TMO), .CHECK_ADDR(1'b1)) dut_f (
    .clk(clk), .n_rst(n_rst), .rx_data(rx_data), .rx_data_ready(rx_data_ready),
    .eop(eop), .rx_error(rx_error), .dev_addr(dev_addr),
    .tok_valid(tv_f), .tok_pid(pid_f), .tok_addr(addr_f), .tok_endp(endp_f),
    .pid_err(pe_f), .crc_err(ce_f), .pkt_err(ke_f), .busy(busy_f));

  always #5 clk = ~clk;

  typedef enum logic [1:0] {K_TOK = 2'd0, K_PID = 2'd1, K_CRC = 2'd2, K_PKT = 2'd3} kind_t;
  typedef struct packed {
    kind_t      kind;
    logic [3:0] pid;
    logic [6:0] addr;
    logic [3:0] endp;
  } ev_t;

  ev_t q_a[$];
  ev_t q_f[$];
  logic [14:0] last_a = 15'd0;
  logic [14:0] last_f = 15'd0;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected flag vector {tok_valid, pid_err, crc_err, pkt_err} for an event kind.
  function automatic logic [3:0] flags_of(input kind_t k);
    logic [3:0] one;
    one = 4'b1000;
    return one >> k;
  endfunction

  ev_t ev_a, ev_f;

  always @(negedge clk) begin
    if (n_rst && (tv_a || pe_a || ce_a || ke_a)) begin
      if (q_a.size() == 0) begin
        check("a_unexpected_pulse", {28'd0, tv_a, pe_a, ce_a, ke_a}, 32'd0);
      end else begin
        ev_a = q_a.pop_front();
        check("a_flags", {28'd0, tv_a, pe_a, ce_a, ke_a}, {28'd0, flags_of(ev_a.kind)});
        check("a_fields", {17'd0, pid_a, addr_a, endp_a}, {17'd0, ev_a.pid, ev_a.addr, ev_a.endp});
      end
    end
    if (n_rst && (tv_f || pe_f || ce_f || ke_f)) begin
      if (q_f.size() == 0) begin
        check("f_unexpected_pulse", {28'd0, tv_f, pe_f, ce_f, ke_f}, 32'd0);
      end else begin
        ev_f = q_f.pop_front();
        check("f_flags", {28'd0, tv_f, pe_f, ce_f, ke_f}, {28'd0, flags_of(ev_f.kind)});
        check("f_fields", {17'd0, pid_f, addr_f, endp_f}, {17'd0, ev_f.pid, ev_f.addr, ev_f.endp});
      end
    end
  end

  task automatic exp_tok(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp);
    last_a = {pid, addr, endp};
    q_a.push_back({K_TOK, last_a});
    if (pid == 4'h5 || addr == dev_addr) begin
      last_f = {pid, addr, endp};
      q_f.push_back({K_TOK, last_f});
    end
  endtask

  task automatic exp_err(input kind_t k);
    q_a.push_back({k, last_a});
    q_f.push_back({k, last_f});
  endtask

  task automatic strobe(input logic [7:0] b, input logic rdy, input logic e);
    rx_data = b; rx_data_ready = rdy; eop = e;
    @(posedge clk); #1;
    rx_data_ready = 1'b0; eop = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic byte_gap(input logic [7:0] b);
    strobe(b, 1'b1, 1'b0);
    idle(2);
  endtask

  task automatic end_pkt();
    strobe(8'h00, 1'b0, 1'b1);
  endtask

  task automatic pkt3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    byte_gap(b0); byte_gap(b1); byte_gap(b2); end_pkt();
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200; i++) begin
      if (q_a.size() == 0 && q_f.size() == 0) break;
      idle(1);
    end
    idle(2);
    check({name, "_pending_a"}, q_a.size(), 32'd0);
    check({name, "_pending_f"}, q_f.size(), 32'd0);
    q_a.delete();
    q_f.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_a"}, {14'd0, tv_a, pid_a, addr_a, endp_a, pe_a, ce_a, ke_a, busy_a}, 32'd0);
    check({name, "_f"}, {14'd0, tv_f, pid_f, addr_f, endp_f, pe_f, ce_f, ke_f, busy_f}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_reset_outputs("reset_state");
    n_rst = 1'b1;
    idle(3);

    // SETUP addr 0 endp 0: filtering instance drops it silently.
    exp_tok(4'hD, 7'd0, 4'd0);
    pkt3(8'h2D, 8'h00, 8'h10);
    drain("setup_a0");

    // Corrupt CRC: error pulse on both, token fields hold.
    exp_err(K_CRC);
    pkt3(8'h2D, 8'h00, 8'h11);
    drain("crc_bad");

    // Bad PID check: one pid_err, busy through discard, idle after eop.
    exp_err(K_PID);
    byte_gap(8'h2C); byte_gap(8'h00); byte_gap(8'h10);
    check("pid_bad_busy", {30'd0, busy_a, busy_f}, 32'd3);
    end_pkt();
    idle(1);
    check("pid_bad_idle", {30'd0, busy_a, busy_f}, 32'd0);
    drain("pid_bad");

    // Short packet then a good one.
    exp_err(K_PKT);
    byte_gap(8'h2D); byte_gap(8'h00); end_pkt();
    drain("short");
    exp_tok(4'hD, 7'd0, 4'd0);
    pkt3(8'h2D, 8'h00, 8'h10);
    drain("after_short");

    // Inter-byte timeout: nothing early, pkt_err after TMO silent clocks.
    exp_err(K_PKT);
    strobe(8'h2D, 1'b1, 1'b0);
    idle(TMO - 4);
    check("timeout_not_early", q_a.size(), 32'd1);
    drain("timeout");
    check("timeout_busy", {30'd0, busy_a, busy_f}, 32'd0);

    // OUT addr 0 endp 1.
    exp_tok(4'h1, 7'd0, 4'd1);
    pkt3(8'hE1, 8'h80, 8'hA0);
    drain("out_ep1");

    // SOF bypasses the address filter; frame bits map to addr/endp.
    exp_tok(4'h5, 7'd0, 4'd0);
    pkt3(8'hA5, 8'h00, 8'h10);
    drain("sof");

    // Byte and eop together while waiting for eop.
    exp_err(K_PKT);
    byte_gap(8'h2D); byte_gap(8'h00); byte_gap(8'h10);
    strobe(8'h33, 1'b1, 1'b1);
    drain("collide_eopw");

    // Byte and eop together in IDLE: taken as PID.
    exp_tok(4'hD, 7'd0, 4'd0);
    strobe(8'h2D, 1'b1, 1'b1); idle(2);
    byte_gap(8'h00); byte_gap(8'h10); end_pkt();
    drain("collide_idle");

    // Extra byte: one pkt_err, then silence through discard.
    exp_err(K_PKT);
    byte_gap(8'h2D); byte_gap(8'h00); byte_gap(8'h10); byte_gap(8'h55);
    byte_gap(8'h66); end_pkt();
    drain("extra_byte");

    // Non-token PID (DATA0): discarded silently.
    byte_gap(8'hC3); byte_gap(8'h12);
    check("data_busy", {30'd0, busy_a, busy_f}, 32'd3);
    byte_gap(8'h34); end_pkt();
    drain("data_pid");

    // Line error aborts with no pulse.
    byte_gap(8'h2D); byte_gap(8'h00);
    rx_error = 1'b1; idle(1); rx_error = 1'b0;
    idle(1);
    check("rx_error_idle", {30'd0, busy_a, busy_f}, 32'd0);
    end_pkt();
    drain("rx_error");

    // SETUP to addr 5: both instances accept.
    exp_tok(4'hD, 7'd5, 4'd0);
    pkt3(8'h2D, 8'h05, 8'hD0);
    drain("setup_a5");

    // Reset mid-packet, then a fresh packet.
    byte_gap(8'h2D); byte_gap(8'h05);
    n_rst = 1'b0;
    #2;
    check_reset_outputs("midpkt_reset");
    last_a = 15'd0;
    last_f = 15'd0;
    idle(2);
    n_rst = 1'b1;
    idle(2);
    exp_tok(4'hD, 7'd5, 4'd0);
    pkt3(8'h2D, 8'h05, 8'hD0);
    drain("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
